// File: rtl/game_board_pkg.sv
// game_board_pkg: shared encodings for the board manager and its line scanner
package game_board_pkg;
  localparam logic [1:0] CELL_BLANK = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;
  localparam logic TURN_PLAYER = 1'b0;
  localparam logic TURN_AI     = 1'b1;
  typedef enum logic [1:0] {GS_PLAYING, GS_WIN_X, GS_WIN_O, GS_DRAW} gs_t;
  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_AD} dir_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_OVER} st_t;
  function automatic int board_w(int rows, int cols);
    return 2 * rows * cols;
  endfunction
endpackage

// File: rtl/game_line_scan.sv
// game_line_scan: walks the four lines through the last move, one cell per cycle,
// and reports whether any of them holds WIN_LEN matching symbols in a row.
module game_line_scan import game_board_pkg::*; #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int WIN_LEN = 3,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int IW = $clog2(ROWS * COLS)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_clear,
  input  logic          i_start,
  input  logic [RW-1:0] i_row,
  input  logic [CW-1:0] i_col,
  input  logic [1:0]    i_sym,
  input  logic [1:0]    i_cell,
  output logic [IW-1:0] o_idx,
  output logic          o_done,
  output logic          o_win
);
  logic            r_active, r_side, r_brk_p, r_brk_n, r_win;
  dir_t            r_dir;
  logic [4:0]      r_k;
  logic [5:0]      r_run;
  logic signed [RW:0] w_kr, w_r;
  logic signed [CW:0] w_kc, w_c;
  logic            w_on, w_hit, w_brk, w_last_k, w_dir_end;
  logic [5:0]      w_run;
  always_comb begin
    w_kr = $signed(r_k[RW:0]);
    w_kc = $signed(r_k[CW:0]);
    w_r = $signed({1'b0, i_row}) + (r_dir == DIR_H ? '0 : r_side ? -w_kr : w_kr);
    // the anti-diagonal runs against the column axis, so its column step flips sign
    w_c = $signed({1'b0, i_col}) + (r_dir == DIR_V ? '0 : ((r_dir == DIR_AD) ^ r_side) ? -w_kc : w_kc);
    w_on = !w_r[RW] && int'(w_r) < ROWS && !w_c[CW] && int'(w_c) < COLS;
    o_idx = w_on ? IW'(int'(w_r) * COLS + int'(w_c)) : '0;
    w_hit = w_on && i_cell == i_sym;
    w_brk = r_side ? r_brk_n : r_brk_p;
    w_run = r_run + {5'b0, w_hit && !w_brk};
    w_last_k = r_k == 5'(WIN_LEN - 1);
    w_dir_end = w_last_k && r_side;
    o_done = r_active && w_dir_end && r_dir == DIR_AD;
    o_win = r_win || (w_dir_end && int'(w_run) >= WIN_LEN);
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_active <= 1'b0;
      r_dir <= DIR_H;
      r_side <= 1'b0;
      r_k <= 5'd1;
      r_run <= 6'd1;
      r_brk_p <= 1'b0;
      r_brk_n <= 1'b0;
      r_win <= 1'b0;
    end else if (i_clear || i_start) begin
      r_active <= i_start && !i_clear;
      r_dir <= DIR_H;
      r_side <= 1'b0;
      r_k <= 5'd1;
      r_run <= 6'd1;
      r_brk_p <= 1'b0;
      r_brk_n <= 1'b0;
      r_win <= 1'b0;
    end else if (r_active) begin
      r_run <= w_dir_end ? 6'd1 : w_run;
      r_k <= w_last_k ? 5'd1 : r_k + 5'd1;
      if (!w_hit && r_side) r_brk_n <= 1'b1;
      if (!w_hit && !r_side) r_brk_p <= 1'b1;
      if (w_last_k) r_side <= !r_side;
      if (w_dir_end) begin
        r_dir <= dir_t'(r_dir + 2'd1);
        r_brk_p <= 1'b0;
        r_brk_n <= 1'b0;
        r_win <= o_win;
      end
      if (o_done) r_active <= 1'b0;
    end
  end
endmodule

// File: rtl/game_board.sv
// game_board: ROWS x COLS board with move handshake, turn tracking and win/draw detection.
module game_board import game_board_pkg::*; #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int WIN_LEN = 3,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int IW = $clog2(ROWS * COLS),
  localparam int NW = $clog2(ROWS * COLS + 1),
  localparam int BW = board_w(ROWS, COLS)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_game_clear,
  input  logic          i_move_valid,
  output logic          o_move_ready,
  input  logic [RW-1:0] i_move_row,
  input  logic [CW-1:0] i_move_col,
  output logic          o_move_err,
  output logic          o_turn,
  output logic [BW-1:0] o_board,
  output logic [1:0]    o_game_state,
  output logic          o_scan_busy
);
  logic [BW-1:0] r_board;
  logic          r_turn, r_err, r_busy;
  gs_t           r_gs;
  st_t           r_st;
  logic [NW-1:0] r_cnt;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [1:0]    r_sym;
  logic          w_hs, w_in, w_legal, w_rej, w_done, w_win, w_full;
  logic [IW-1:0] w_midx, w_sidx;
  logic [1:0]    w_mcell, w_scell;
  always_comb begin
    w_hs = i_move_valid && r_st != ST_SCAN;
    w_in = int'(i_move_row) < ROWS && int'(i_move_col) < COLS;
    w_midx = w_in ? IW'(int'(i_move_row) * COLS + int'(i_move_col)) : '0;
    w_mcell = r_board[{w_midx, 1'b0} +: 2];
    w_legal = w_hs && r_st != ST_OVER && w_in && w_mcell == CELL_BLANK;
    w_rej = w_hs && !w_legal;
    w_scell = r_board[{w_sidx, 1'b0} +: 2];
    w_full = int'(r_cnt) == ROWS * COLS;
    o_move_ready = r_st != ST_SCAN;
    o_move_err = r_err;
    o_turn = r_turn;
    o_board = r_board;
    o_game_state = r_gs;
    o_scan_busy = r_busy;
  end
  game_line_scan #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) u_scan (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_clear(i_game_clear),
    .i_start(w_legal && !i_game_clear),
    .i_row(r_row),
    .i_col(r_col),
    .i_sym(r_sym),
    .i_cell(w_scell),
    .o_idx(w_sidx),
    .o_done(w_done),
    .o_win(w_win)
  );
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_board <= '0;
      r_turn <= TURN_PLAYER;
      r_gs <= GS_PLAYING;
      r_err <= 1'b0;
      r_busy <= 1'b0;
      r_cnt <= '0;
      r_st <= ST_IDLE;
      r_row <= '0;
      r_col <= '0;
      r_sym <= CELL_BLANK;
    end else if (i_game_clear) begin
      r_board <= '0;
      r_turn <= TURN_PLAYER;
      r_gs <= GS_PLAYING;
      r_err <= 1'b0;
      r_busy <= 1'b0;
      r_cnt <= '0;
      r_st <= ST_IDLE;
      r_row <= '0;
      r_col <= '0;
      r_sym <= CELL_BLANK;
    end else begin
      r_err <= w_rej;
      if (w_legal) begin
        r_board[{w_midx, 1'b0} +: 2] <= r_turn == TURN_AI ? CELL_O : CELL_X;
        r_turn <= !r_turn;
        r_cnt <= r_cnt + NW'(1);
        r_row <= i_move_row;
        r_col <= i_move_col;
        r_sym <= r_turn == TURN_AI ? CELL_O : CELL_X;
        r_st <= ST_SCAN;
        r_busy <= 1'b1;
      end
      if (r_st == ST_SCAN && w_done) begin
        r_busy <= 1'b0;
        r_st <= w_win || w_full ? ST_OVER : ST_IDLE;
        r_gs <= w_win ? (r_sym == CELL_X ? GS_WIN_X : GS_WIN_O) : w_full ? GS_DRAW : GS_PLAYING;
      end
    end
  end
endmodule

// File: tb/tb_game_board.sv
// tb_game_board: scoreboard bench for a default 3x3 board and a 5x5 connect-4 board
module tb_game_board;
  logic clk = 1'b0;
  logic rst_n, clear, a_valid, b_valid;
  logic [2:0] row, col;
  logic a_ready, a_err, a_turn, a_busy, b_ready, b_err, b_turn, b_busy;
  logic [17:0] a_board;
  logic [49:0] b_board;
  logic [1:0] a_gs, b_gs;
  int nchk = 0, nerr = 0;
  typedef struct {bit err; int gs; bit turn; int blen; logic [49:0] board;} exp_t;
  exp_t q[$];
  int mb[2][5][5];
  bit mturn[2], mover[2];
  int mcnt[2], mgs[2];
  always #5 clk = ~clk;
  game_board dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_game_clear(clear), .i_move_valid(a_valid),
    .o_move_ready(a_ready), .i_move_row(row[1:0]), .i_move_col(col[1:0]), .o_move_err(a_err),
    .o_turn(a_turn), .o_board(a_board), .o_game_state(a_gs), .o_scan_busy(a_busy)
  );
  game_board #(.ROWS(5), .COLS(5), .WIN_LEN(4)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_game_clear(clear), .i_move_valid(b_valid),
    .o_move_ready(b_ready), .i_move_row(row), .i_move_col(col), .o_move_err(b_err),
    .o_turn(b_turn), .o_board(b_board), .o_game_state(b_gs), .o_scan_busy(b_busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] brd(bit s);
    return s ? 64'(b_board) : 64'(a_board);
  endfunction
  function automatic logic [49:0] mflat(bit s);
    logic [49:0] f = '0;
    int n = s ? 5 : 3;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) f[2*(r*n+c) +: 2] = 2'(mb[s][r][c]);
    return f;
  endfunction
  function automatic bit mwin(bit s, int sym);
    int n = s ? 5 : 3;
    int w = s ? 4 : 3;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          int dr = d == 0 ? 0 : 1;
          int dc = d == 1 ? 0 : d == 3 ? -1 : 1;
          bit ok = 1;
          for (int k = 0; k < w; k++) begin
            int rr = r + k * dr;
            int cc = c + k * dc;
            if (rr < 0 || rr >= n || cc < 0 || cc >= n || mb[s][rr][cc] != sym) ok = 0;
          end
          if (ok) return 1;
        end
    return 0;
  endfunction
  task automatic mclr();
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) mb[s][r][c] = 0;
      mturn[s] = 0; mover[s] = 0; mcnt[s] = 0; mgs[s] = 0;
    end
  endtask
  task automatic chk_reset(input bit s, input string tag);
    check({tag, "_ready"}, s ? b_ready : a_ready, 1);
    check({tag, "_err"}, s ? b_err : a_err, 0);
    check({tag, "_busy"}, s ? b_busy : a_busy, 0);
    check({tag, "_turn"}, s ? b_turn : a_turn, 0);
    check({tag, "_gs"}, s ? b_gs : a_gs, 0);
    check({tag, "_board"}, brd(s), 0);
  endtask
  task automatic do_clear();
    @(negedge clk) clear = 1;
    @(posedge clk) #1 clear = 0;
    mclr();
  endtask
  task automatic mv(input bit s, input int r, input int c);
    exp_t e;
    int n = s ? 5 : 3;
    int sym;
    int cnt;
    e.err = mover[s] || r >= n || c >= n || mb[s][r][c] != 0;
    if (!e.err) begin
      sym = mturn[s] ? 2 : 1;
      mb[s][r][c] = sym;
      mturn[s] = !mturn[s];
      mcnt[s]++;
      if (mwin(s, sym)) begin mgs[s] = sym; mover[s] = 1; end
      else if (mcnt[s] == n * n) begin mgs[s] = 3; mover[s] = 1; end
    end
    e.gs = mgs[s];
    e.turn = mturn[s];
    e.blen = e.err ? 0 : 8 * ((s ? 4 : 3) - 1);
    e.board = mflat(s);
    q.push_back(e);
    @(negedge clk);
    row = 3'(r);
    col = 3'(c);
    if (s) b_valid = 1; else a_valid = 1;
    check("ready", s ? b_ready : a_ready, 1);
    @(posedge clk) #1;
    a_valid = 0;
    b_valid = 0;
    e = q.pop_front();
    check("err", s ? b_err : a_err, e.err);
    cnt = 0;
    while ((s ? b_busy : a_busy) && cnt < 100) begin
      @(posedge clk) #1;
      cnt++;
    end
    check("busy_len", cnt, e.blen);
    check("gs", s ? b_gs : a_gs, e.gs);
    check("turn", s ? b_turn : a_turn, e.turn);
    check("board", brd(s), 64'(e.board));
    if (e.err) begin
      @(posedge clk) #1;
      check("err_pulse", s ? b_err : a_err, 0);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 0; clear = 0; a_valid = 0; b_valid = 0; row = 0; col = 0;
    mclr();
    repeat (3) @(posedge clk);
    #1 chk_reset(0, "rst_a");
    chk_reset(1, "rst_b");
    @(negedge clk) rst_n = 1;
    mv(0, 0, 0); mv(0, 1, 0); mv(0, 0, 1); mv(0, 1, 1); mv(0, 0, 2);
    check("win_x", a_gs, 1);
    mv(0, 2, 2);
    do_clear();
    mv(0, 0, 0); mv(0, 0, 0); mv(0, 3, 1); mv(0, 1, 1);
    do_clear();
    mv(0, 0, 0); mv(0, 0, 1); mv(0, 0, 2); mv(0, 1, 1); mv(0, 1, 0);
    mv(0, 2, 0); mv(0, 1, 2); mv(0, 2, 2); mv(0, 2, 1);
    check("draw", a_gs, 3);
    mv(0, 0, 0);
    mv(1, 0, 0); mv(1, 0, 4); mv(1, 1, 0); mv(1, 1, 3); mv(1, 2, 0);
    mv(1, 3, 1); mv(1, 4, 4); mv(1, 2, 2);
    check("win_o", b_gs, 2);
    do_clear();
    mv(1, 0, 0); mv(1, 2, 4); mv(1, 1, 0); mv(1, 4, 2); mv(1, 0, 2); mv(1, 3, 3);
    check("edge_nowin", b_gs, 0);
    do_clear();
    @(negedge clk) row = 0; col = 0; a_valid = 1;
    @(posedge clk) #1 a_valid = 0;
    check("scan_start", a_busy, 1);
    repeat (4) @(posedge clk);
    @(negedge clk) clear = 1; a_valid = 1; row = 1; col = 1;
    @(posedge clk) #1 chk_reset(0, "clear");
    clear = 0;
    a_valid = 0;
    mclr();
    mv(0, 1, 1);
    do_clear();
    mv(0, 0, 0);
    @(negedge clk) row = 1; col = 1; a_valid = 1;
    @(posedge clk) #1 a_valid = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1 chk_reset(0, "areset_a");
    chk_reset(1, "areset_b");
    @(negedge clk) rst_n = 1;
    mclr();
    mv(0, 2, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/game_board.md
Name: game_board

Overview:
- Clocked, parametrised successor to the fixed 3x3 board manager.
- Holds an ROWS x COLS board of 2-bit cells and accepts player/AI moves through a valid/ready handshake.
- Alternates turns and rejects illegal moves.
- After each accepted move, runs a fixed-latency sequential line scan that detects a WIN_LEN-in-a-row win or a draw.
- Sits between the player/AI move sources and the display/status logic.

Parameters:
- ROWS, 3, board rows (2..16)
- COLS, 3, board columns (2..16)
- WIN_LEN, 3, consecutive same-symbol cells needed to win (2..min(ROWS,COLS))

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- game_clear  in  1  synchronous new-game request, single-cycle pulse
- move_valid  in  1  move request present
- move_ready  out  1  block can accept a move
- move_row  in  clog2(ROWS)  target row
- move_col  in  clog2(COLS)  target column
- move_err  out  1  one-cycle pulse: the move was accepted on the handshake but rejected
- turn  out  1  side to move: TURN_PLAYER=0 (X), TURN_AI=1 (O)
- board  out  2*ROWS*COLS  flat cell vector; cell (r,c) sits at bits [2*(r*COLS+c) +: 2]
- game_state  out  2  GS_PLAYING=0, GS_WIN_X=1, GS_WIN_O=2, GS_DRAW=3
- scan_busy  out  1  high while the win scan is in progress

Behaviour:
- Reset (reset_n low, asynchronous) sets:
  - board = all CELL_BLANK; turn = TURN_PLAYER; game_state = GS_PLAYING
  - move_err = 0; scan_busy = 0; move_ready = 1; move counter = 0; FSM = IDLE
- game_clear has the same effect as reset, applied on the clock edge. It has priority over a simultaneous handshake and aborts a scan in progress.
- FSM states: IDLE, SCAN, OVER.
  - move_ready = 1 in IDLE and OVER; 0 in SCAN.
- Handshake: a move is taken on a rising edge where move_valid && move_ready.
- Rejection cases. The handshake still completes, but the board and turn are unchanged, move_err pulses on the next cycle, and the FSM stays where it is:
  - state is OVER;
  - move_row >= ROWS or move_col >= COLS;
  - the target cell is not CELL_BLANK.
- Legal move, all on the same edge:
  - target cell <= CELL_X if turn == TURN_PLAYER, otherwise CELL_O;
  - turn toggles; move counter increments;
  - the move coordinates and symbol are latched;
  - FSM -> SCAN; scan_busy = 1.
- SCAN order: directions H(0,+1), V(+1,0), D(+1,+1), AD(+1,-1).
  - For each direction, step k = 1..WIN_LEN-1 along +dir, then k = 1..WIN_LEN-1 along -dir.
  - Exactly one cell is examined per cycle, so SCAN lasts exactly 8*(WIN_LEN-1) cycles (16 for the defaults).
- Run counting:
  - run starts at 1 for each direction;
  - each side keeps a "broken" flag, set when a cell is off-board or its value differs from the latched symbol;
  - a cell that is on-board, matches, and whose side is not broken adds 1 to run.
  - Signed coordinate arithmetic is one bit wider than the row/column widths; off-board means < 0 or >= ROWS/COLS.
  - Win when run >= WIN_LEN in any direction.
- SCAN exit, on the edge after the last examined cell:
  - win: game_state = GS_WIN_X or GS_WIN_O from the latched symbol; FSM -> OVER.
  - no win and move counter == ROWS*COLS: game_state = GS_DRAW; FSM -> OVER.
  - otherwise: FSM -> IDLE.
  - scan_busy drops on the same edge in every case.
- In OVER, only reset_n or game_clear leave the state; any move is rejected with move_err.
- move_err never pulses on the edge of a legal move.
- The board output is registered and shows the new cell the cycle after acceptance.

Decomposition:
- Shared package / defines file holds:
  - CELL_BLANK=2'b00, CELL_X=2'b01, CELL_O=2'b10;
  - TURN_PLAYER, TURN_AI;
  - GS_* encodings;
  - direction encodings;
  - a width macro for flat board vectors.
- One sub-module, game_line_scan, contains:
  - the direction/step counters;
  - the signed coordinate generator;
  - per-side broken flags and run accumulation.
  - It outputs the cell index to read, scan_done and win.
- game_board keeps the board registers, the handshake, turn, the move counter and the top FSM.

Test Plan:
- Defaults. Reset, then play X(0,0), O(1,0), X(0,1), O(1,1), X(0,2), waiting out each scan -> after the last scan game_state=GS_WIN_X; every scan_busy window is exactly 16 cycles.
- Move into occupied (0,0), then row=3 (out of range) -> move_err pulses twice; board and turn unchanged; FSM back in IDLE.
- Full 9-move game with no line, e.g. X at (0,0),(0,2),(1,0),(1,2),(2,1) and O at (0,1),(1,1),(2,0),(2,2) -> game_state=GS_DRAW; a 10th move gives move_err.
- ROWS=5, COLS=5, WIN_LEN=4: O completes the anti-diagonal (0,4),(1,3),(2,2),(3,1), the last move placed in the middle -> GS_WIN_O. Same board with a 3-run plus an edge (off-board) cell -> no win.
- Assert game_clear 5 cycles into a scan, together with move_valid -> next cycle: board all zero, turn=0, game_state=GS_PLAYING, scan_busy=0, move ignored.
- Drop reset_n between clock edges mid-game -> outputs reach reset values immediately without a clock edge; first move after release accepted normally.
